// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer on refclk: pulses the PLL reset, waits for lock with
// timeout, qualifies lock stability, then releases core reset; re-locks on loss.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 742500,
  parameter int unsigned STABLE_CYCLES = 4096,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked_in,
  input  logic             relock_req,
  output logic             pll_rst,
  output logic             core_reset,
  output logic             clk_ready,
  output logic [CNT_W-1:0] relock_cnt,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    QUALIFY   = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int unsigned CYC_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CYC_MAX   = (CYC_MAX_A > STABLE_CYCLES) ? CYC_MAX_A : STABLE_CYCLES;
  localparam int unsigned CYC_W     = (CYC_MAX < 2) ? 1 : $clog2(CYC_MAX);

  localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] TMO_LAST = CYC_W'(LOCK_TIMEOUT - 1);
  localparam logic [CYC_W-1:0] STB_LAST = CYC_W'(STABLE_CYCLES - 1);

  state_t                 r_state;
  logic [CYC_W-1:0]       r_cyc;
  logic [SYNC_STAGES-1:0] r_sync;

  state_t w_next;
  logic   w_locked_s;
  logic   w_timeout;
  logic   w_loss;
  logic   w_entry;

  assign w_locked_s = r_sync[SYNC_STAGES-1];
  assign state_o    = r_state;

  // Next-state decode; relock_req overrides timeout and lock loss so neither is counted.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    w_loss    = 1'b0;
    if (relock_req) begin
      w_next = PLL_RESET;
    end else begin
      case (r_state)
        PLL_RESET: if (r_cyc == RST_LAST) w_next = WAIT_LOCK;
        WAIT_LOCK: begin
          if (w_locked_s) begin
            w_next = QUALIFY;
          end else if (r_cyc == TMO_LAST) begin
            w_next    = PLL_RESET;
            w_timeout = 1'b1;
          end
        end
        QUALIFY: begin
          if (!w_locked_s)           w_next = WAIT_LOCK;
          else if (r_cyc == STB_LAST) w_next = RUN;
        end
        RUN: begin
          if (!w_locked_s) begin
            w_next = PLL_RESET;
            w_loss = 1'b1;
          end
        end
      endcase
    end
  end

  // A relock request while already in PLL_RESET counts as a fresh entry.
  assign w_entry = relock_req || (w_next != r_state);

  // State, cycle counter, synchronizer and outputs; outputs track the state being entered.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state     <= PLL_RESET;
      r_cyc       <= '0;
      r_sync      <= '0;
      pll_rst     <= 1'b1;
      core_reset  <= 1'b1;
      clk_ready   <= 1'b0;
      relock_cnt  <= '0;
      timeout_cnt <= '0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], locked_in};
      r_state    <= w_next;
      pll_rst    <= (w_next == PLL_RESET);
      core_reset <= (w_next != RUN);
      clk_ready  <= (w_next == RUN);
      if (w_entry)              r_cyc <= '0;
      else if (r_state != RUN)  r_cyc <= r_cyc + CYC_W'(1);
      if (w_timeout && (timeout_cnt != '1)) timeout_cnt <= timeout_cnt + CNT_W'(1);
      if (w_loss && (relock_cnt != '1))     relock_cnt  <= relock_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: stimulus pushes cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pll_lock_sequencer;
  localparam int unsigned CNT_W = 2;

  logic             refclk = 1'b0;
  logic             rst = 1'b1;
  logic             locked_in = 1'b0;
  logic             relock_req = 1'b0;
  logic             pll_rst;
  logic             core_reset;
  logic             clk_ready;
  logic [CNT_W-1:0] relock_cnt;
  logic [CNT_W-1:0] timeout_cnt;
  logic [1:0]       state_o;

  pll_lock_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(100), .STABLE_CYCLES(8), .SYNC_STAGES(2), .CNT_W(CNT_W)
  ) dut (
    .refclk(refclk), .rst(rst), .locked_in(locked_in), .relock_req(relock_req),
    .pll_rst(pll_rst), .core_reset(core_reset), .clk_ready(clk_ready),
    .relock_cnt(relock_cnt), .timeout_cnt(timeout_cnt), .state_o(state_o)
  );

  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic [1:0] rc;
    logic [1:0] tc;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   base = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc - base);
    end
  endtask

  task automatic push_exp(input int k, input logic [1:0] st, input logic [1:0] rc,
                          input logic [1:0] tc, input string tag);
    sb.push_back('{base + k, st, rc, tc, tag});
  endtask

  task automatic wait_to(input int k);
    while (cyc < base + k) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    locked_in = 1'b0;
    relock_req = 1'b0;
    repeat (3) @(posedge refclk);
    #1;
    base = cyc;
    push_exp(0, 2'd0, 2'd0, 2'd0, "reset");
    rst = 1'b0;
  endtask

  // Monitor: compare every expectation due this cycle; core_reset/clk_ready/pll_rst follow the state.
  always @(negedge refclk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        check_eq({e.tag, "_late"}, 32'(cyc), 32'(e.cyc));
      end else begin
        check_eq({e.tag, "_state"},       32'(state_o),     32'(e.st));
        check_eq({e.tag, "_pll_rst"},     32'(pll_rst),     32'(e.st == 2'd0));
        check_eq({e.tag, "_core_reset"},  32'(core_reset),  32'(e.st != 2'd3));
        check_eq({e.tag, "_clk_ready"},   32'(clk_ready),   32'(e.st == 2'd3));
        check_eq({e.tag, "_relock_cnt"},  32'(relock_cnt),  32'(e.rc));
        check_eq({e.tag, "_timeout_cnt"}, 32'(timeout_cnt), 32'(e.tc));
      end
    end
  end

  initial begin
    int guard;

    // Timeout with no lock
    do_reset();
    for (int k = 1; k < 4; k++) push_exp(k, 2'd0, 2'd0, 2'd0, "t1_pllrst");
    push_exp(4,   2'd1, 2'd0, 2'd0, "t1_wait");
    push_exp(103, 2'd1, 2'd0, 2'd0, "t1_wait_last");
    push_exp(104, 2'd0, 2'd0, 2'd1, "t1_timeout");
    push_exp(107, 2'd0, 2'd0, 2'd1, "t1_pllrst_end");
    push_exp(108, 2'd1, 2'd0, 2'd1, "t1_rewait");
    wait_to(110);

    // Clean lock to RUN
    do_reset();
    push_exp(4,  2'd1, 2'd0, 2'd0, "t2_wait");
    push_exp(6,  2'd1, 2'd0, 2'd0, "t2_sync");
    push_exp(7,  2'd2, 2'd0, 2'd0, "t2_qual");
    push_exp(14, 2'd2, 2'd0, 2'd0, "t2_qual_last");
    push_exp(15, 2'd3, 2'd0, 2'd0, "t2_run");
    wait_to(4);
    locked_in = 1'b1;
    wait_to(17);

    // Glitch in QUALIFY, then lock loss, relock priority, saturation and mid-run reset
    do_reset();
    push_exp(4,  2'd1, 2'd0, 2'd0, "t3_wait");
    push_exp(7,  2'd2, 2'd0, 2'd0, "t3_qual");
    push_exp(11, 2'd2, 2'd0, 2'd0, "t3_qual5");
    push_exp(12, 2'd2, 2'd0, 2'd0, "t3_glitch");
    push_exp(13, 2'd1, 2'd0, 2'd0, "t3_back_wait");
    push_exp(14, 2'd2, 2'd0, 2'd0, "t3_requal");
    push_exp(21, 2'd2, 2'd0, 2'd0, "t3_requal_last");
    push_exp(22, 2'd3, 2'd0, 2'd0, "t3_run");
    wait_to(4);
    locked_in = 1'b1;
    wait_to(10);
    locked_in = 1'b0;
    wait_to(11);
    locked_in = 1'b1;

    push_exp(32, 2'd3, 2'd0, 2'd0, "t4_run_hold");
    for (int k = 33; k < 37; k++) push_exp(k, 2'd0, 2'd1, 2'd0, "t4_pllrst");
    push_exp(37, 2'd1, 2'd1, 2'd0, "t4_wait");
    push_exp(40, 2'd2, 2'd1, 2'd0, "t4_qual");
    push_exp(47, 2'd2, 2'd1, 2'd0, "t4_qual_last");
    push_exp(48, 2'd3, 2'd1, 2'd0, "t4_run");
    wait_to(30);
    locked_in = 1'b0;
    wait_to(37);
    locked_in = 1'b1;

    push_exp(56, 2'd3, 2'd1, 2'd0, "t5_run");
    push_exp(57, 2'd3, 2'd1, 2'd0, "t5_req");
    push_exp(58, 2'd0, 2'd1, 2'd0, "t5_pllrst");
    push_exp(59, 2'd0, 2'd1, 2'd0, "t5_req2");
    for (int k = 60; k < 64; k++) push_exp(k, 2'd0, 2'd1, 2'd0, "t5_extend");
    push_exp(64, 2'd1, 2'd1, 2'd0, "t5_wait");
    wait_to(55);
    locked_in = 1'b0;
    wait_to(57);
    relock_req = 1'b1;
    wait_to(58);
    relock_req = 1'b0;
    wait_to(59);
    relock_req = 1'b1;
    wait_to(60);
    relock_req = 1'b0;

    push_exp(163, 2'd1, 2'd1, 2'd0, "t6_wait_last");
    push_exp(164, 2'd0, 2'd1, 2'd1, "t6_tmo1");
    push_exp(268, 2'd0, 2'd1, 2'd2, "t6_tmo2");
    push_exp(372, 2'd0, 2'd1, 2'd3, "t6_tmo3");
    push_exp(476, 2'd0, 2'd1, 2'd3, "t6_tmo4_sat");
    push_exp(580, 2'd0, 2'd1, 2'd3, "t6_tmo5_sat");
    push_exp(584, 2'd1, 2'd1, 2'd3, "t6_wait");
    push_exp(600, 2'd1, 2'd1, 2'd3, "t6_pre_rst");
    push_exp(601, 2'd0, 2'd0, 2'd0, "t6_rst");
    wait_to(600);
    rst = 1'b1;
    wait_to(602);
    rst = 1'b0;

    guard = 0;
    while (sb.size() > 0 && guard < 50) begin
      @(posedge refclk);
      guard++;
    end
    check_eq("sb_drain", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
